// File: rtl/aes_ct_compare_monitor_pkg.sv
// Shared definitions for the AES ciphertext compare monitor.
// Holds the block width, default FIFO depth, default counter width,
// default alarm threshold and a constant-evaluable clog2 helper used to
// size FIFO pointers.
package aes_ct_compare_monitor_pkg;

  localparam int AES_BLK_W        = 128;
  localparam int MON_DEPTH        = 4;
  localparam int MON_CNT_W        = 16;
  localparam int MON_ALARM_THRESH = 1;

  // Ceiling log2 of value; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/aes_mon_fifo.sv
// Synchronous FIFO buffering one ciphertext stream of the compare monitor.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-low (empties the FIFO)
//   push       in   write push_data (ignored when full)
//   push_data  in   DATA_W block to store
//   pop        in   drop the head entry (ignored when empty)
//   full       out  no free entry
//   empty      out  no stored entry
//   head       out  oldest stored block (meaningful only when !empty)
module aes_mon_fifo
  import aes_ct_compare_monitor_pkg::*;
#(
  parameter int DATA_W = AES_BLK_W,
  parameter int DEPTH  = MON_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // The extra pointer MSB tells a full FIFO (MSBs differ) from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/aes_ct_compare_monitor.sv
// Runtime Trojan-detection monitor: compares the suspect AES core's
// ciphertext stream block-by-block against a golden core's stream.
// Each stream has its own FIFO so the cores may differ in latency.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   p_data/valid/ready  suspect-core ciphertext stream
//   r_data/valid/ready  golden-core ciphertext stream
//   clear               clear counter, alarm and first_diff (FIFOs kept)
//   cmp_valid           one-cycle pulse per compared block pair
//   cmp_match           result of that compare
//   mism_cnt            saturating count of mismatching pairs
//   first_diff          p^r of the first mismatch since reset/clear
//   alarm               sticky, set once mism_cnt reaches ALARM_THRESH
module aes_ct_compare_monitor
  import aes_ct_compare_monitor_pkg::*;
#(
  parameter int DATA_W       = AES_BLK_W,
  parameter int DEPTH        = MON_DEPTH,
  parameter int CNT_W        = MON_CNT_W,
  parameter int ALARM_THRESH = MON_ALARM_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic              clear,
  output logic              cmp_valid,
  output logic              cmp_match,
  output logic [CNT_W-1:0]  mism_cnt,
  output logic [DATA_W-1:0] first_diff,
  output logic              alarm
);

  logic              p_full, p_empty, r_full, r_empty;
  logic [DATA_W-1:0] p_head, r_head, diff;
  logic              do_cmp, is_mism;
  logic [CNT_W-1:0]  cnt_base, cnt_upd;

  // Ready depends only on full, so a full FIFO refuses a push even while popping.
  assign p_ready = rst && !p_full;
  assign r_ready = rst && !r_full;
  assign do_cmp  = !p_empty && !r_empty;
  assign diff    = p_head ^ r_head;
  assign is_mism = do_cmp && (diff != '0);

  aes_mon_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_p_fifo (
    .clk(clk), .rst(rst), .push(p_valid && p_ready), .push_data(p_data),
    .pop(do_cmp), .full(p_full), .empty(p_empty), .head(p_head)
  );

  aes_mon_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_r_fifo (
    .clk(clk), .rst(rst), .push(r_valid && r_ready), .push_data(r_data),
    .pop(do_cmp), .full(r_full), .empty(r_empty), .head(r_head)
  );

  // A clear zeroes the count first, so a same-cycle mismatch becomes the
  // first event after the clear. The count saturates instead of wrapping.
  always_comb begin
    cnt_base = clear ? '0 : mism_cnt;
    cnt_upd  = cnt_base;
    if (is_mism && (cnt_base != '1)) cnt_upd = cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmp_valid  <= 1'b0;
      cmp_match  <= 1'b0;
      mism_cnt   <= '0;
      first_diff <= '0;
      alarm      <= 1'b0;
    end else begin
      cmp_valid <= do_cmp;
      if (do_cmp) cmp_match <= (diff == '0);
      mism_cnt <= cnt_upd;
      if (is_mism && (cnt_base == '0)) first_diff <= diff;
      else if (clear)                  first_diff <= '0;
      alarm <= (alarm && !clear) || (is_mism && (cnt_upd >= CNT_W'(ALARM_THRESH)));
    end
  end

endmodule

// File: tb/tb_aes_ct_compare_monitor.sv
// Self-checking bench for aes_ct_compare_monitor. Two instances share the
// same stimulus: one with default counter/threshold, one with a 2-bit
// counter and threshold 2. Expected values come from a queue-based model
// of the two streams plus per-instance counter/alarm/first_diff models.
module tb_aes_ct_compare_monitor;
  import aes_ct_compare_monitor_pkg::*;

  localparam int W     = AES_BLK_W;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] p_data = '0, r_data = '0;
  logic         p_valid = 1'b0, r_valid = 1'b0, clear = 1'b0;

  logic         p_ready_a, r_ready_a, cmp_valid_a, cmp_match_a, alarm_a;
  logic [15:0]  mism_cnt_a;
  logic [W-1:0] first_diff_a;
  logic         p_ready_b, r_ready_b, cmp_valid_b, cmp_match_b, alarm_b;
  logic [1:0]   mism_cnt_b;
  logic [W-1:0] first_diff_b;

  aes_ct_compare_monitor #(.DATA_W(W), .DEPTH(DEPTH), .CNT_W(16), .ALARM_THRESH(1)) dut_a (
    .clk(clk), .rst(rst), .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready_a),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready_a), .clear(clear),
    .cmp_valid(cmp_valid_a), .cmp_match(cmp_match_a), .mism_cnt(mism_cnt_a),
    .first_diff(first_diff_a), .alarm(alarm_a)
  );

  aes_ct_compare_monitor #(.DATA_W(W), .DEPTH(DEPTH), .CNT_W(2), .ALARM_THRESH(2)) dut_b (
    .clk(clk), .rst(rst), .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready_b),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready_b), .clear(clear),
    .cmp_valid(cmp_valid_b), .cmp_match(cmp_match_b), .mism_cnt(mism_cnt_b),
    .first_diff(first_diff_b), .alarm(alarm_b)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] q_p [$];
  logic [W-1:0] q_r [$];
  int           exp_cnt   [2];
  logic [W-1:0] exp_fd    [2];
  logic         exp_alarm [2];
  int           cnt_max   [2];
  int           thresh    [2];
  logic         exp_cv, exp_cm;
  logic         last_p_acc, last_r_acc;

  int n_total = 0;
  int n_pass  = 0;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drives one cycle of inputs, advances the model across the edge and
  // compares every output of both instances against it.
  task automatic applyStimulus(input logic pv, input logic [W-1:0] pd,
                               input logic rv, input logic [W-1:0] rd, input logic clr);
    logic         exp_pr, exp_rr, do_pop;
    logic [W-1:0] hp, hr;
    p_valid = pv; p_data = pd; r_valid = rv; r_data = rd; clear = clr;
    #1;
    exp_pr = rst && (q_p.size() < DEPTH);
    exp_rr = rst && (q_r.size() < DEPTH);
    checkOutput("p_ready_a", W'(p_ready_a), W'(exp_pr));
    checkOutput("r_ready_a", W'(r_ready_a), W'(exp_rr));
    checkOutput("p_ready_b", W'(p_ready_b), W'(exp_pr));
    checkOutput("r_ready_b", W'(r_ready_b), W'(exp_rr));
    last_p_acc = pv && exp_pr;
    last_r_acc = rv && exp_rr;
    @(posedge clk);
    if (!rst) begin
      q_p.delete(); q_r.delete();
      exp_cv = 1'b0; exp_cm = 1'b0;
      for (int i = 0; i < 2; i++) begin
        exp_cnt[i] = 0; exp_fd[i] = '0; exp_alarm[i] = 1'b0;
      end
    end else begin
      do_pop = (q_p.size() > 0) && (q_r.size() > 0);
      hp = '0; hr = '0;
      exp_cv = do_pop;
      if (do_pop) begin
        hp = q_p.pop_front();
        hr = q_r.pop_front();
        exp_cm = (hp == hr);
      end
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          exp_cnt[i] = 0; exp_fd[i] = '0; exp_alarm[i] = 1'b0;
        end
        if (do_pop && (hp != hr)) begin
          if (exp_cnt[i] == 0) exp_fd[i] = hp ^ hr;
          if (exp_cnt[i] < cnt_max[i]) exp_cnt[i]++;
          if (exp_cnt[i] >= thresh[i]) exp_alarm[i] = 1'b1;
        end
      end
      if (last_p_acc) q_p.push_back(pd);
      if (last_r_acc) q_r.push_back(rd);
    end
    #1;
    checkOutput("cmp_valid_a", W'(cmp_valid_a), W'(exp_cv));
    checkOutput("cmp_valid_b", W'(cmp_valid_b), W'(exp_cv));
    if (exp_cv || !rst) begin
      checkOutput("cmp_match_a", W'(cmp_match_a), W'(exp_cm));
      checkOutput("cmp_match_b", W'(cmp_match_b), W'(exp_cm));
    end
    checkOutput("mism_cnt_a", W'(mism_cnt_a), W'(exp_cnt[0]));
    checkOutput("mism_cnt_b", W'(mism_cnt_b), W'(exp_cnt[1]));
    checkOutput("first_diff_a", first_diff_a, exp_fd[0]);
    checkOutput("first_diff_b", first_diff_b, exp_fd[1]);
    checkOutput("alarm_a", W'(alarm_a), W'(exp_alarm[0]));
    checkOutput("alarm_b", W'(alarm_b), W'(exp_alarm[1]));
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rndBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] blk [8];
    logic [W-1:0] rp [64];
    logic [W-1:0] rr [64];
    int p_sent, r_sent;
    cnt_max[0] = 65535; cnt_max[1] = 3;
    thresh[0]  = 1;     thresh[1]  = 2;
    exp_cv = 1'b0; exp_cm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_cnt[i] = 0; exp_fd[i] = '0; exp_alarm[i] = 1'b0;
    end

    // Reset
    rst = 1'b0;
    repeat (3) applyStimulus(0, '0, 0, '0, 0);
    rst = 1'b1;
    applyStimulus(0, '0, 0, '0, 0);

    $display("[TB] match test");
    blk[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    applyStimulus(1, blk[0], 1, blk[0], 0);
    repeat (3) applyStimulus(0, '0, 0, '0, 0);

    $display("[TB] skew test");
    for (int i = 0; i < 3; i++) blk[i] = rndBlock();
    for (int i = 0; i < 6; i++)
      applyStimulus(i >= 3, (i >= 3) ? blk[i-3] : '0, i < 3, (i < 3) ? blk[i] : '0, 0);
    repeat (2) applyStimulus(0, '0, 0, '0, 0);

    $display("[TB] corruption test");
    for (int i = 0; i < 3; i++) blk[i] = rndBlock();
    for (int i = 0; i < 3; i++)
      applyStimulus(1, (i == 1) ? (blk[i] ^ 128'h1) : blk[i], 1, blk[i], 0);
    repeat (2) applyStimulus(0, '0, 0, '0, 0);
    applyStimulus(0, '0, 0, '0, 1);

    $display("[TB] back-pressure test");
    for (int i = 0; i < 6; i++) blk[i] = rndBlock();
    p_sent = 0; r_sent = 0;
    for (int s = 0; s < 20; s++) begin
      applyStimulus(p_sent < 6, blk[p_sent % 6], (s >= 6) && (r_sent < 6), blk[r_sent % 6], 0);
      if (last_p_acc) p_sent++;
      if (last_r_acc) r_sent++;
    end
    checkOutput("bp_p_accepted", W'(p_sent), W'(6));
    checkOutput("bp_r_accepted", W'(r_sent), W'(6));

    $display("[TB] saturation/clear test");
    for (int i = 0; i < 5; i++) begin
      blk[0] = rndBlock();
      applyStimulus(1, blk[0] ^ 128'h80, 1, blk[0], 0);
    end
    repeat (2) applyStimulus(0, '0, 0, '0, 0);
    blk[0] = rndBlock();
    applyStimulus(1, blk[0] ^ 128'hf00d, 1, blk[0], 0);
    applyStimulus(0, '0, 0, '0, 1);
    applyStimulus(0, '0, 0, '0, 0);

    $display("[TB] random test");
    for (int i = 0; i < 64; i++) begin
      rp[i] = rndBlock();
      rr[i] = ($urandom_range(0, 3) == 0) ? (rp[i] ^ rndBlock()) : rp[i];
    end
    p_sent = 0; r_sent = 0;
    for (int s = 0; s < 250; s++) begin
      applyStimulus(($urandom_range(0, 9) < 7) && (p_sent < 64), rp[p_sent % 64],
                    ($urandom_range(0, 9) < 6) && (r_sent < 64), rr[r_sent % 64],
                    $urandom_range(0, 19) == 0);
      if (last_p_acc) p_sent++;
      if (last_r_acc) r_sent++;
    end
    repeat (6) applyStimulus(0, '0, 0, '0, 0);

    $display("[TB] reset mid-stream test");
    for (int i = 0; i < 2; i++) applyStimulus(1, rndBlock(), 0, '0, 0);
    rst = 1'b0;
    repeat (2) applyStimulus(0, '0, 1, rndBlock(), 0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(0, '0, 1, rndBlock(), 0);
    repeat (3) applyStimulus(0, '0, 0, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
